// File: rtl/add_subt_issue_ctrl.sv
// Issue/capture controller in front of the FP add/subtract FSM: buffers one
// operand pair, pulses beg/rst to the FSM, and holds the result for downstream.
module add_subt_issue_ctrl #(
  parameter int W     = 32,
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_op_a,
  input  logic [W-1:0]     in_op_b,
  input  logic             in_add_subt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [LAT_W-1:0] out_latency,
  output logic             beg_FSM_o,
  output logic             rst_FSM_o,
  output logic [W-1:0]     Data_X_o,
  output logic [W-1:0]     Data_Y_o,
  output logic             add_subt_o,
  input  logic             ready_i,
  input  logic [W-1:0]     result_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_t           state, state_nxt;
  logic [W-1:0]     buf_a, buf_b;
  logic             buf_op, op_full;
  logic [LAT_W-1:0] lat_cnt, lat_inc;
  logic             accept, transfer, capture, pop;

  assign in_ready  = ~op_full;
  assign accept    = in_valid & ~op_full;
  assign pop       = out_valid & out_ready;
  assign lat_inc   = (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 1'b1;
  assign beg_FSM_o = (state == S_ISSUE);
  assign rst_FSM_o = (state == S_RELEASE);
  assign busy_o    = (state != S_IDLE);

  // Issue waits for ready_i low so a lingering ready from the previous op
  // is never mistaken for completion of the new one.
  always_comb begin
    state_nxt = state;
    transfer  = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (op_full && !ready_i) begin
          transfer  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ready_i && (!out_valid || pop)) begin
          capture   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (!ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // accept and transfer are mutually exclusive: accept needs op_full=0,
  // transfer needs op_full=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_a   <= '0;
      buf_b   <= '0;
      buf_op  <= 1'b0;
      op_full <= 1'b0;
    end else if (accept) begin
      buf_a   <= in_op_a;
      buf_b   <= in_op_b;
      buf_op  <= in_add_subt;
      op_full <= 1'b1;
    end else if (transfer) begin
      op_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Data_X_o   <= '0;
      Data_Y_o   <= '0;
      add_subt_o <= 1'b0;
    end else if (transfer) begin
      Data_X_o   <= buf_a;
      Data_Y_o   <= buf_b;
      add_subt_o <= buf_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   lat_cnt <= '0;
    else if (transfer)         lat_cnt <= '0;
    else if (state == S_WAIT)  lat_cnt <= lat_inc;
  end

  // Capture reports lat_inc so the capture cycle itself is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_latency <= '0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_result  <= result_i;
      out_latency <= lat_inc;
    end else if (pop) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_subt_issue_ctrl.sv
// Bench for add_subt_issue_ctrl: behavioural FSM/datapath model plus a
// result scoreboard built from the operands the bench sends.
module tb_add_subt_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op_a = '0, in_op_b = '0;
  logic        in_add_subt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [7:0]  out_latency;
  logic        beg_FSM_o, rst_FSM_o;
  logic [31:0] Data_X_o, Data_Y_o;
  logic        add_subt_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_i = '0;
  logic        busy_o;

  add_subt_issue_ctrl #(.W(32), .LAT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_add_subt(in_add_subt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_latency(out_latency),
    .beg_FSM_o(beg_FSM_o), .rst_FSM_o(rst_FSM_o),
    .Data_X_o(Data_X_o), .Data_Y_o(Data_Y_o), .add_subt_o(add_subt_o),
    .ready_i(ready_i), .result_i(result_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; int lat; } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   beg_cnt = 0;
  int   rst_cnt = 0;
  int   dly_q[$];
  exp_t exp_q[$];

  // Imaginary datapath: the one known float case, else plain integer math.
  function automatic logic [31:0] dp(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return 32'h4040_0000;
    return s ? a - b : a + b;
  endfunction

  // FSM model and protocol monitor share one negedge process so the monitor
  // always reads last cycle's ready before the model updates it.
  int          fsm_cnt = 0;
  bit          fsm_run = 0, fsm_rel = 0, in_flight = 0;
  bit          prev_beg = 0, prev_rst = 0, prev_ready = 0, beg_saw_full = 0;
  logic [31:0] fsm_res = '0, hold_x = '0, hold_y = '0;
  logic        hold_s = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      ready_i = 1'b0; fsm_run = 0; fsm_rel = 0; in_flight = 0;
      prev_beg = 0; prev_rst = 0; prev_ready = 0;
    end else begin
      if (beg_FSM_o) begin
        beg_cnt++;
        checks++;
        if (rst_FSM_o || prev_beg)
          $display("FAIL beg_pulse: beg=%0b rst_FSM=%0b prev_beg=%0b, required single isolated pulse", beg_FSM_o, rst_FSM_o, prev_beg);
        if (rst_FSM_o || prev_beg) errors++;
        beg_saw_full = out_valid;
        hold_x = Data_X_o; hold_y = Data_Y_o; hold_s = add_subt_o;
        in_flight = 1;
      end else if (in_flight) begin
        checks++;
        if (Data_X_o !== hold_x || Data_Y_o !== hold_y || add_subt_o !== hold_s) begin
          errors++;
          $display("FAIL stable_ops: X=%h Y=%h s=%0b, required X=%h Y=%h s=%0b", Data_X_o, Data_Y_o, add_subt_o, hold_x, hold_y, hold_s);
        end
      end
      if (rst_FSM_o) begin
        rst_cnt++;
        checks++;
        if (prev_rst || !prev_ready || !out_valid) begin
          errors++;
          $display("FAIL rst_pulse: prev_rst=%0b prev_ready=%0b out_valid=%0b, required 0/1/1", prev_rst, prev_ready, out_valid);
        end
        in_flight = 0;
      end
      prev_beg = beg_FSM_o;
      prev_rst = rst_FSM_o;

      if (fsm_rel) begin
        ready_i = 1'b0; result_i = $urandom; fsm_run = 0; fsm_rel = 0;
      end else if (ready_i && rst_FSM_o) begin
        fsm_rel = 1;
      end
      if (beg_FSM_o) begin
        fsm_run = 1;
        fsm_cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 2;
        fsm_res = dp(Data_X_o, Data_Y_o, add_subt_o);
      end else if (fsm_run && !ready_i) begin
        fsm_cnt--;
        if (fsm_cnt <= 0) begin ready_i = 1'b1; result_i = fsm_res; end
      end
      prev_ready = ready_i;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input int d, input bit chk_lat);
    int   t = 0;
    exp_t e;
    in_op_a = a; in_op_b = b; in_add_subt = s; in_valid = 1'b1;
    while (!in_ready && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      in_valid = 1'b0;
      return;
    end
    dly_q.push_back(d);
    e.res = dp(a, b, s);
    e.lat = chk_lat ? ((d > 255) ? 255 : d) : -1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string nm);
    int   t = 0;
    exp_t e;
    while (!out_valid && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_valid: out_valid=0 after %0d cycles, required 1", nm, t);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_extra: result %h present, required none", nm, out_result);
    end else begin
      e = exp_q.pop_front();
      if (out_result !== e.res) begin
        errors++;
        $display("FAIL %s_result: got %h, required %h", nm, out_result, e.res);
      end
      if (e.lat >= 0) begin
        checks++;
        if (out_latency !== 8'(e.lat)) begin
          errors++;
          $display("FAIL %s_latency: got %0d, required %0d", nm, out_latency, e.lat);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({out_valid, beg_FSM_o, rst_FSM_o, busy_o, add_subt_o} !== 5'b0 ||
        Data_X_o !== '0 || Data_Y_o !== '0 || out_result !== '0 || out_latency !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ov=%0b beg=%0b rstf=%0b busy=%0b X=%h Y=%h res=%h lat=%0d in_ready=%0b, required all 0 and in_ready=1",
               nm, out_valid, beg_FSM_o, rst_FSM_o, busy_o, Data_X_o, Data_Y_o, out_result, out_latency, in_ready);
    end
  endtask

  task automatic test_reset();
    int b0, r0;
    #12;
    check_idle_outputs("reset_power_on");
    @(negedge clk); rst = 1'b0;
    send(32'h1111_0000, 32'h0000_2222, 1'b0, 50, 1'b1);
    send(32'h3333_0000, 32'h0000_4444, 1'b1, 5, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre: busy=%0b in_ready=%0b, required 1/0", busy_o, in_ready);
    end
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset_held");
    dly_q.delete(); exp_q.delete();
    @(negedge clk); rst = 1'b0;
    b0 = beg_cnt; r0 = rst_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (beg_cnt != b0 || rst_cnt != r0 || busy_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: beg=%0d rst=%0d busy=%0b ov=%0b, required 0 0 0 0", beg_cnt - b0, rst_cnt - r0, busy_o, out_valid);
    end
  endtask

  task automatic test_single_op();
    int b0 = beg_cnt, r0 = rst_cnt;
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 12, 1'b1);
    expect_result("single");
    repeat (5) @(negedge clk);
    checks++;
    if (beg_cnt - b0 != 1 || rst_cnt - r0 != 1) begin
      errors++;
      $display("FAIL single_pulses: beg=%0d rst=%0d, required 1 1", beg_cnt - b0, rst_cnt - r0);
    end
  endtask

  task automatic test_back_pressure();
    int b0 = beg_cnt, r0 = rst_cnt, t = 0;
    out_ready = 1'b0;
    send($urandom, $urandom, 1'b0, 4, 1'b1);
    send($urandom, $urandom, 1'b1, 3, 1'b0);
    send($urandom, $urandom, 1'b0, 6, 1'b1);
    while (!(ready_i && beg_cnt - b0 == 2) && t < 200) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || ready_i !== 1'b1 || rst_cnt - r0 != 1 || beg_cnt - b0 != 2 || !beg_saw_full) begin
      errors++;
      $display("FAIL bp_stall: busy=%0b ready=%0b rst=%0d beg=%0d beg_after_capture=%0b, required 1 1 1 2 1",
               busy_o, ready_i, rst_cnt - r0, beg_cnt - b0, beg_saw_full);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%0b out_valid=%0b, required 0 1", in_ready, out_valid);
    end
    expect_result("bp0");
    expect_result("bp1");
    expect_result("bp2");
  endtask

  task automatic test_capture_pop();
    int   t = 0;
    exp_t ea, eb;
    out_ready = 1'b0;
    send($urandom, $urandom, 1'b1, 5, 1'b1);
    send($urandom, $urandom, 1'b0, 8, 1'b1);
    while (!out_valid && t < 200) begin @(negedge clk); t++; end
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_result !== ea.res) begin
      errors++;
      $display("FAIL cp_first: ov=%0b res=%h, required 1 %h", out_valid, out_result, ea.res);
    end
    t = 0;
    while (ready_i && t < 2000) begin #1; t++; end
    while (!ready_i && t < 4000) begin #1; t++; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== eb.res || out_latency !== 8'(eb.lat)) begin
      errors++;
      $display("FAIL cp_swap: ov=%0b res=%h lat=%0d, required 1 %h %0d", out_valid, out_result, out_latency, eb.res, eb.lat);
    end
    exp_q.push_front(eb);
    expect_result("cp_second");
  endtask

  task automatic test_saturation();
    send(32'h0BAD_F00D, 32'h0000_0001, 1'b1, 300, 1'b1);
    expect_result("sat");
  endtask

  task automatic test_stable_operands();
    send($urandom, $urandom, 1'b1, 20, 1'b1);
    send($urandom, $urandom, 1'b0, 7, 1'b1);
    for (int i = 0; i < 15; i++) begin
      in_op_a = $urandom; in_op_b = $urandom; in_add_subt = 1'($urandom);
      @(negedge clk);
    end
    expect_result("stable0");
    expect_result("stable1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom), $urandom_range(2, 15), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      expect_result("rand");
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_back_pressure();
    test_capture_pop();
    test_saturation();
    test_stable_operands();
    test_random();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: pending=%0d ov=%0b busy=%0b, required 0 0 0", exp_q.size(), out_valid, busy_o);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
